// File: rtl/dest_hazard_unit.sv
// Follows each instruction's write-destination register through EX, MEM and WB.
// Produces EX operand forwarding selects, the ID load-use stall and the WB write port.
module dest_hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_wreg,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [REG_W-1:0] ex_wreg,
  output logic [REG_W-1:0] wb_wreg,
  output logic             wb_regwrite
);

  localparam logic [REG_W-1:0] ZERO_REG = {REG_W{1'b0}};

  logic [REG_W-1:0] ex_rs_r;
  logic [REG_W-1:0] ex_rt_r;
  logic [REG_W-1:0] ex_wreg_r;
  logic             ex_uses_rt_r;
  logic             ex_regwrite_r;
  logic             ex_memread_r;
  logic [REG_W-1:0] mem_wreg_r;
  logic             mem_regwrite_r;
  logic [REG_W-1:0] wb_wreg_r;
  logic             wb_regwrite_r;

  logic             stall_s;
  logic             bubble_s;
  logic [1:0]       fwd_a_s;
  logic [1:0]       fwd_b_s;

  // Register 0 is hard-wired, so it never counts as a dependency.
  function automatic logic reg_hit(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
    return (dst != ZERO_REG) && (dst == src);
  endfunction

  // Newest producer wins: MEM is checked before WB.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             mem_rw,
    input logic [REG_W-1:0] mem_wr,
    input logic             wb_rw,
    input logic [REG_W-1:0] wb_wr
  );
    logic [1:0] sel;
    if (mem_rw && reg_hit(mem_wr, src)) begin
      sel = 2'b01;
    end else if (wb_rw && reg_hit(wb_wr, src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Load-use detection and forwarding-select decode.
  always_comb begin
    stall_s = 1'b0;
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (id_valid && ex_memread_r && ex_regwrite_r &&
        (reg_hit(ex_wreg_r, id_rs) || (id_uses_rt && reg_hit(ex_wreg_r, id_rt)))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
    fwd_a_s = fwd_sel(ex_rs_r, mem_regwrite_r, mem_wreg_r, wb_regwrite_r, wb_wreg_r);
    if (ex_uses_rt_r) begin
      fwd_b_s = fwd_sel(ex_rt_r, mem_regwrite_r, mem_wreg_r, wb_regwrite_r, wb_wreg_r);
    end else begin
      fwd_b_s = 2'b00;
    end
  end

  assign bubble_s = stall_s | flush;

  // Pipeline advance: MEM and WB always shift; EX takes ID or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs_r        <= ZERO_REG;
      ex_rt_r        <= ZERO_REG;
      ex_wreg_r      <= ZERO_REG;
      ex_uses_rt_r   <= 1'b0;
      ex_regwrite_r  <= 1'b0;
      ex_memread_r   <= 1'b0;
      mem_wreg_r     <= ZERO_REG;
      mem_regwrite_r <= 1'b0;
      wb_wreg_r      <= ZERO_REG;
      wb_regwrite_r  <= 1'b0;
    end else begin
      wb_wreg_r      <= mem_wreg_r;
      wb_regwrite_r  <= mem_regwrite_r;
      mem_wreg_r     <= ex_wreg_r;
      mem_regwrite_r <= ex_regwrite_r;
      if (bubble_s) begin
        ex_rs_r       <= ZERO_REG;
        ex_rt_r       <= ZERO_REG;
        ex_wreg_r     <= ZERO_REG;
        ex_uses_rt_r  <= 1'b0;
        ex_regwrite_r <= 1'b0;
        ex_memread_r  <= 1'b0;
      end else begin
        ex_rs_r       <= id_rs;
        ex_rt_r       <= id_rt;
        ex_wreg_r     <= id_wreg;
        ex_uses_rt_r  <= id_uses_rt;
        ex_regwrite_r <= id_valid & id_regwrite;
        ex_memread_r  <= id_valid & id_memread;
      end
    end
  end

  assign stall       = stall_s;
  assign fwd_a       = fwd_a_s;
  assign fwd_b       = fwd_b_s;
  assign ex_wreg     = ex_wreg_r;
  assign wb_wreg     = wb_wreg_r;
  assign wb_regwrite = wb_regwrite_r;

endmodule

// File: tb/tb_dest_hazard_unit.sv
// Directed bench for dest_hazard_unit: forwarding, load-use stall, flush and reset.
module tb_dest_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] id_wreg;
  logic       id_regwrite;
  logic       id_memread;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [4:0] ex_wreg;
  logic [4:0] wb_wreg;
  logic       wb_regwrite;

  int vec_cnt = 0;
  int err_cnt = 0;

  dest_hazard_unit #(.REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_wreg(id_wreg), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .flush(flush), .stall(stall), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .ex_wreg(ex_wreg), .wb_wreg(wb_wreg), .wb_regwrite(wb_regwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] wr, input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_wreg = wr; id_regwrite = rw; id_memread = mr;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Advance one rising edge, then return on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    nop();
    tick(); tick(); tick();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    nop();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
             5'($urandom), 1'($urandom), 1'($urandom));
      flush = 1'($urandom);
    end
    chk("rst_hold_wb_regwrite", {7'd0, wb_regwrite}, 8'd0);
    chk("rst_hold_stall", {7'd0, stall}, 8'd0);
    @(negedge clk);
    flush = 1'b0;
    nop();
    rst_n = 1'b1;
    #1;
    chk("rst_stall", {7'd0, stall}, 8'd0);
    chk("rst_fwd_a", {6'd0, fwd_a}, 8'd0);
    chk("rst_fwd_b", {6'd0, fwd_b}, 8'd0);
    chk("rst_wb_regwrite", {7'd0, wb_regwrite}, 8'd0);
    chk("rst_wb_wreg", {3'd0, wb_wreg}, 8'd0);
    chk("rst_ex_wreg", {3'd0, ex_wreg}, 8'd0);

    // ALU back-to-back: add $3; sub $10,$3,$3; or $11,$1,$2
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0);
    chk("b2b_ex_wreg", {3'd0, ex_wreg}, 8'd3);
    tick();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0);
    chk("b2b_fwd_a", {6'd0, fwd_a}, 8'd1);
    chk("b2b_fwd_b", {6'd0, fwd_b}, 8'd1);
    tick();
    nop();
    chk("b2b_wb_wreg", {3'd0, wb_wreg}, 8'd3);
    chk("b2b_wb_regwrite", {7'd0, wb_regwrite}, 8'd1);
    chk("b2b_unrel_fwd_a", {6'd0, fwd_a}, 8'd0);
    chk("b2b_unrel_fwd_b", {6'd0, fwd_b}, 8'd0);
    drain();

    // Distance 2: add $5; nop; or rs=5
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    tick();
    nop();
    chk("dist2_fwd_a", {6'd0, fwd_a}, 8'd2);
    chk("dist2_fwd_b", {6'd0, fwd_b}, 8'd0);
    drain();

    // Priority: add $5; add $5; or rs=5
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    tick();
    nop();
    chk("prio_fwd_a", {6'd0, fwd_a}, 8'd1);
    drain();

    // Load-use: lw $8; add rs=8
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd8, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0);
    chk("lu_stall", {7'd0, stall}, 8'd1);
    tick();
    chk("lu_bubble_ex_wreg", {3'd0, ex_wreg}, 8'd0);
    chk("lu_stall_once", {7'd0, stall}, 8'd0);
    chk("lu_bubble_fwd_a", {6'd0, fwd_a}, 8'd0);
    tick();
    nop();
    chk("lu_fwd_a", {6'd0, fwd_a}, 8'd2);
    chk("lu_fwd_b", {6'd0, fwd_b}, 8'd0);
    chk("lu_stall_after", {7'd0, stall}, 8'd0);
    chk("lu_wb_wreg", {3'd0, wb_wreg}, 8'd8);
    chk("lu_ex_wreg", {3'd0, ex_wreg}, 8'd13);
    drain();

    // Load followed by independent instruction
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd9, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0);
    chk("indep_stall", {7'd0, stall}, 8'd0);
    tick();
    nop();
    chk("indep_ex_wreg", {3'd0, ex_wreg}, 8'd13);
    drain();

    // Register 0 is never forwarded
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd14, 1'b1, 1'b0);
    tick();
    nop();
    chk("r0_fwd_a", {6'd0, fwd_a}, 8'd0);
    chk("r0_fwd_b", {6'd0, fwd_b}, 8'd0);
    drain();

    // lw $0; add rs=0 -> no stall
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd14, 1'b1, 1'b0);
    chk("r0_lw_stall", {7'd0, stall}, 8'd0);
    drain();

    // lw $7; addi with rt=7 but uses_rt=0
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd1, 5'd7, 1'b0, 5'd15, 1'b1, 1'b0);
    chk("urt_stall", {7'd0, stall}, 8'd0);
    tick();
    nop();
    chk("urt_fwd_b", {6'd0, fwd_b}, 8'd0);
    drain();

    // Flush: add $4 never tracked
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd4, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    nop();
    chk("flush_ex_wreg", {3'd0, ex_wreg}, 8'd0);
    tick();
    tick();
    chk("flush_wb_regwrite", {7'd0, wb_regwrite}, 8'd0);
    drain();

    // Flush plus stall together: add $6; lw $8; add rs=8 with flush
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd6, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd8, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("fs_stall", {7'd0, stall}, 8'd1);
    tick();
    flush = 1'b0;
    nop();
    chk("fs_ex_wreg", {3'd0, ex_wreg}, 8'd0);
    chk("fs_wb_wreg", {3'd0, wb_wreg}, 8'd6);
    chk("fs_wb_regwrite", {7'd0, wb_regwrite}, 8'd1);
    tick();
    chk("fs_lw_wb_wreg", {3'd0, wb_wreg}, 8'd8);
    chk("fs_lw_wb_regwrite", {7'd0, wb_regwrite}, 8'd1);
    drain();

    // Asynchronous reset mid-flight: add $9 reaches WB, then reset between edges
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    tick();
    chk("ar_pre_wb_regwrite", {7'd0, wb_regwrite}, 8'd1);
    chk("ar_pre_wb_wreg", {3'd0, wb_wreg}, 8'd9);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_wb_regwrite", {7'd0, wb_regwrite}, 8'd0);
    chk("ar_wb_wreg", {3'd0, wb_wreg}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
